// File: rtl/instr_loader_pkg.sv
// Shared widths and FSM state encoding for the boot-time instruction loader.
package instr_loader_pkg;

  localparam int INSTR_W         = 24;
  localparam int ADDR_W          = 8;
  localparam int BYTES_PER_INSTR = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_COUNT = 3'd1,
    ST_B0    = 3'd2,
    ST_B1    = 3'd3,
    ST_B2    = 3'd4,
    ST_CKSUM = 3'd5,
    ST_DONE  = 3'd6,
    ST_ERR   = 3'd7
  } state_e;

  // States in which the loader accepts a host byte.
  function automatic logic is_rx_state(input state_e s);
    return (s == ST_COUNT) || (s == ST_B0) || (s == ST_B1) ||
           (s == ST_B2) || (s == ST_CKSUM);
  endfunction

endpackage

// File: rtl/loader_byte_packer.sv
// Shifts accepted payload bytes into a big-endian 24-bit word and flags the
// cycle in which the third byte of a word arrives.
module loader_byte_packer
  import instr_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear_i,
  input  logic               byte_valid_i,
  input  logic [7:0]         byte_i,
  output logic [INSTR_W-1:0] word_o,
  output logic               word_done_o
);

  localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_INSTR - 1);

  logic [15:0] hold_q;
  logic [1:0]  lane_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
      lane_q <= '0;
    end else if (clear_i) begin
      lane_q <= '0;
    end else if (byte_valid_i) begin
      hold_q <= {hold_q[7:0], byte_i};
      lane_q <= (lane_q == LAST_LANE) ? 2'd0 : lane_q + 2'd1;
    end
  end

  // The completed word includes the byte arriving now, so the top can register it directly.
  assign word_o      = {hold_q, byte_i};
  assign word_done_o = byte_valid_i && (lane_q == LAST_LANE);

endmodule

// File: rtl/instr_loader.sv
// Boot loader: receives count/payload/checksum frame, writes 24-bit words into
// instruction memory and keeps the CPU held until a verified load completes.
//
// state | meaning
// IDLE  | after reset, waiting for start, CPU held
// COUNT | waiting for word count N
// B0    | waiting for instr[23:16]
// B1    | waiting for instr[15:8]
// B2    | waiting for instr[7:0], issues the memory write
// CKSUM | waiting for checksum byte
// DONE  | good load, CPU released, start reloads
// ERR   | bad checksum, CPU held, start reloads
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = 8'h00
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [INSTR_W-1:0] mem_wdata,
  output logic               cpu_hold,
  output logic               done,
  output logic               err
);

  state_e             state_q;
  logic [7:0]         n_q;
  logic [8:0]         idx_q;
  logic [8:0]         idx_d;
  logic [7:0]         xor_q;
  logic               in_ready_q;
  logic               mem_we_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [INSTR_W-1:0] mem_wdata_q;
  logic               cpu_hold_q;
  logic               done_q;
  logic               err_q;

  logic               xfer;
  logic               pk_valid;
  logic               pk_clear;
  logic [INSTR_W-1:0] pk_word;
  logic               pk_done;

  assign xfer     = in_valid && in_ready_q;
  assign pk_valid = xfer && ((state_q == ST_B0) || (state_q == ST_B1) || (state_q == ST_B2));
  assign pk_clear = (state_q == ST_COUNT);
  assign idx_d    = idx_q + 9'd1;

  loader_byte_packer u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (pk_clear),
    .byte_valid_i (pk_valid),
    .byte_i       (in_data),
    .word_o       (pk_word),
    .word_done_o  (pk_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      n_q         <= '0;
      idx_q       <= '0;
      xor_q       <= '0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= BASE_ADDR;
      mem_wdata_q <= '0;
      cpu_hold_q  <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            state_q    <= ST_COUNT;
            in_ready_q <= 1'b1;
            cpu_hold_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            idx_q      <= '0;
          end
        end
        ST_COUNT: begin
          if (xfer) begin
            n_q     <= in_data;
            xor_q   <= in_data;
            state_q <= (in_data == 8'd0) ? ST_CKSUM : ST_B0;
          end
        end
        ST_B0: begin
          if (xfer) begin
            xor_q   <= xor_q ^ in_data;
            state_q <= ST_B1;
          end
        end
        ST_B1: begin
          if (xfer) begin
            xor_q   <= xor_q ^ in_data;
            state_q <= ST_B2;
          end
        end
        ST_B2: begin
          if (xfer) begin
            xor_q       <= xor_q ^ in_data;
            mem_we_q    <= pk_done;
            // Address arithmetic is 8-bit, so BASE_ADDR + index wraps FF -> 00.
            mem_addr_q  <= BASE_ADDR + idx_q[7:0];
            mem_wdata_q <= pk_word;
            idx_q       <= idx_d;
            state_q     <= (idx_d == {1'b0, n_q}) ? ST_CKSUM : ST_B0;
          end
        end
        ST_CKSUM: begin
          if (xfer) begin
            in_ready_q <= 1'b0;
            if (in_data == xor_q) begin
              state_q    <= ST_DONE;
              done_q     <= 1'b1;
              cpu_hold_q <= 1'b0;
            end else begin
              state_q <= ST_ERR;
              err_q   <= 1'b1;
            end
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          in_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_hold  = cpu_hold_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: frame vectors on two instances (base 00 and FF)
// plus hand sequences for mid-load reset and address wrap.
module tb_instr_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;

  logic        in_ready_a, mem_we_a, cpu_hold_a, done_a, err_a;
  logic [7:0]  mem_addr_a;
  logic [23:0] mem_wdata_a;
  logic        in_ready_b, mem_we_b, cpu_hold_b, done_b, err_b;
  logic [7:0]  mem_addr_b;
  logic [23:0] mem_wdata_b;

  int total;
  int bad;

  logic [31:0] wq_a[$];
  logic [31:0] wq_b[$];

  instr_loader #(.BASE_ADDR(8'h00)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
    .mem_wdata(mem_wdata_a), .cpu_hold(cpu_hold_a), .done(done_a), .err(err_a)
  );

  instr_loader #(.BASE_ADDR(8'hFF)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
    .mem_wdata(mem_wdata_b), .cpu_hold(cpu_hold_b), .done(done_b), .err(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we_a) wq_a.push_back({mem_addr_a, mem_wdata_a});
    if (mem_we_b) wq_b.push_back({mem_addr_b, mem_wdata_b});
  end

  typedef struct packed {
    logic [7:0]  nb;
    logic [63:0] bytes;
    logic        gap;
    logic [7:0]  nw;
    logic [47:0] words;
    logic        exp_done;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_in_ready", 32'(in_ready_a), 32'd1);
    chk("start_hold", 32'(cpu_hold_a), 32'd1);
    chk("start_clear", {30'd0, done_a, err_a}, 32'd0);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    bit ok;
    if (gap) begin
      in_valid = 1'b0;
      tick();
    end
    in_valid = 1'b1;
    in_data  = b;
    ok = 1'b0;
    for (int c = 0; c < 16 && !ok; c++) begin
      if (in_ready_a) ok = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic chk_writes(input string nm, input int nw, input logic [47:0] words);
    logic [7:0]  ea;
    logic [23:0] ed;
    chk({nm, "_nwr_a"}, 32'(wq_a.size()), 32'(nw));
    chk({nm, "_nwr_b"}, 32'(wq_b.size()), 32'(nw));
    for (int k = 0; k < nw; k++) begin
      ed = words[47-24*k -: 24];
      if (k < wq_a.size()) begin
        ea = 8'h00 + 8'(k);
        chk({nm, "_wr_a"}, wq_a[k], {ea, ed});
      end
      if (k < wq_b.size()) begin
        ea = 8'hFF + 8'(k);
        chk({nm, "_wr_b"}, wq_b[k], {ea, ed});
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;

    vecs[0] = '{nb:8'd8, bytes:64'h0211223344556675, gap:1'b0, nw:8'd2, words:48'h112233445566, exp_done:1'b1};
    vecs[1] = '{nb:8'd8, bytes:64'h0211223344556600, gap:1'b0, nw:8'd2, words:48'h112233445566, exp_done:1'b0};
    vecs[2] = '{nb:8'd2, bytes:64'h0000000000000000, gap:1'b0, nw:8'd0, words:48'h0, exp_done:1'b1};
    vecs[3] = '{nb:8'd8, bytes:64'h0211223344556675, gap:1'b1, nw:8'd2, words:48'h112233445566, exp_done:1'b1};
    vecs[4] = '{nb:8'd5, bytes:64'h01DEADBECC000000, gap:1'b1, nw:8'd1, words:48'hDEADBE000000, exp_done:1'b1};
    vecs[5] = '{nb:8'd2, bytes:64'h005A000000000000, gap:1'b0, nw:8'd0, words:48'h0, exp_done:1'b0};

    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready_a), 32'd0);
    chk("rst_hold", 32'(cpu_hold_a), 32'd1);
    chk("rst_addr_b", 32'(mem_addr_b), 32'h0FF);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("idle_in_ready", 32'(in_ready_a), 32'd0);
    chk("idle_outs", {mem_we_a, done_a, err_a, mem_wdata_a}, 32'd0);

    for (int v = 0; v < 6; v++) begin
      logic [63:0] bb;
      int          nb;
      bb = vecs[v].bytes;
      nb = int'(vecs[v].nb);
      wq_a.delete();
      wq_b.delete();
      do_start();
      for (int k = 0; k < nb; k++) begin
        send_byte(bb[63-8*k -: 8], vecs[v].gap);
        if (k >= 1 && k < nb - 1 && ((k - 1) % 3) == 2)
          chk("we_timing", 32'(mem_we_a), 32'd1);
      end
      chk("done_now", 32'(done_a), 32'(vecs[v].exp_done));
      tick();
      chk("done_a", 32'(done_a), 32'(vecs[v].exp_done));
      chk("err_a", 32'(err_a), 32'(!vecs[v].exp_done));
      chk("hold_a", 32'(cpu_hold_a), 32'(!vecs[v].exp_done));
      chk("done_b", {31'd0, done_b}, 32'(vecs[v].exp_done));
      chk("end_in_ready", 32'(in_ready_a), 32'd0);
      chk_writes("vec", int'(vecs[v].nw), vecs[v].words);
    end

    // Reset in the middle of a load.
    wq_a.delete();
    wq_b.delete();
    do_start();
    send_byte(8'h02, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_state", {in_ready_a, mem_we_a, done_a, err_a, cpu_hold_a}, 32'h1);
    chk("mid_rst_addr", 32'(mem_addr_a), 32'h0);
    chk("mid_rst_data", 32'(mem_wdata_a), 32'h0);
    in_valid = 1'b1;
    in_data = 8'h55;
    tick();
    tick();
    tick();
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    tick();
    chk("mid_rst_nwr", 32'(wq_a.size()), 32'd1);
    chk("post_rst_idle", 32'(in_ready_a), 32'd0);
    wq_a.delete();
    wq_b.delete();
    do_start();
    begin
      logic [63:0] bb;
      bb = 64'h0211223344556675;
      for (int k = 0; k < 8; k++) send_byte(bb[63-8*k -: 8], 1'b0);
    end
    tick();
    chk("reload_done", {30'd0, done_a, err_a}, 32'd2);
    chk_writes("reload", 2, 48'h112233445566);

    // Address wrap on the FF instance; start pulse mid-payload must be ignored.
    wq_a.delete();
    wq_b.delete();
    do_start();
    send_byte(8'h02, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_ignored", 32'(in_ready_b), 32'd1);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'hDF, 1'b0);
    tick();
    chk("wrap_done_b", {30'd0, done_b, err_b}, 32'd2);
    chk("wrap_hold_b", 32'(cpu_hold_b), 32'd0);
    chk_writes("wrap", 2, 48'hAABBCC010203);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
